// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: drains the bridge FIFO read port and issues each entry as an APB write, all on rclk.
// Optional feature macro APB_TIMEOUT_EN adds an ACCESS wait-state timeout with a sticky tout flag.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | no transfer; pops the FIFO head as soon as it is non-empty
//  S_SETUP  | APB setup phase (psel=1, penable=0), always exactly one cycle
//  S_ACCESS | APB access phase (psel=1, penable=1), waits for pready
module apb_master_ctrl #(
    parameter int DSIZE       = 32,
    parameter int AWIDTH      = 32,
    parameter int ECNT_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              fifo_rempty,
    input  logic [DSIZE-1:0]  fifo_rdata,
    input  logic [AWIDTH-1:0] fifo_addr,
    output logic              fifo_rinc,
    output logic [AWIDTH-1:0] paddr,
    output logic [DSIZE-1:0]  pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic [ECNT_W-1:0] err_count,
    output logic              tout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_pop;
    logic              w_err_inc;
    logic              w_limit;
    logic [AWIDTH-1:0] r_paddr;
    logic [DSIZE-1:0]  r_pwdata;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;
    logic [ECNT_W-1:0] r_err_count;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("apb_master_ctrl: TIMEOUT_CYC must be at least 2");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_tout;

    assign w_limit = (r_wait_cnt == CNT_LAST);
`else
    assign w_limit = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_err_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_rempty) begin
                    w_pop  = 1'b1;
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                // completion on pready takes priority over a timeout in the same cycle
                if (pready) begin
                    w_err_inc = pslverr;
                    if (!fifo_rempty) begin
                        w_pop  = 1'b1;
                        w_next = S_SETUP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (w_limit) begin
                    w_err_inc = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state     <= S_IDLE;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state   <= w_next;
            r_psel    <= (w_next != S_IDLE);
            r_penable <= (w_next == S_ACCESS);
            if (w_pop) begin
                r_paddr  <= fifo_addr;
                r_pwdata <= fifo_rdata;
                r_pwrite <= 1'b1;
            end else if (w_next == S_IDLE) begin
                r_pwrite <= 1'b0;
            end
            if (w_err_inc && (r_err_count != {ECNT_W{1'b1}})) begin
                r_err_count <= r_err_count + ECNT_W'(1);
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    // SETUP always leads to ACCESS, so clearing here restarts the count on every ACCESS entry
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_wait_cnt <= '0;
            r_tout     <= 1'b0;
        end else begin
            if (r_state == S_SETUP) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !pready && !w_limit) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if ((r_state == S_ACCESS) && !pready && w_limit) begin
                r_tout <= 1'b1;
            end
        end
    end

    assign tout = r_tout;
`else
    assign tout = 1'b0;
`endif

    // the pop strobe is held low while reset is asserted even if the FIFO head is valid
    assign fifo_rinc = w_pop & rrst_n;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pwrite    = r_pwrite;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign busy      = (r_state != S_IDLE);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: a queue-based FIFO and APB slave model drive the DUT,
// observed APB completions are compared with the order and values popped from the FIFO.
module tb_apb_master_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          fifo_rempty;
    logic [DW-1:0] fifo_rdata;
    logic [AW-1:0] fifo_addr;
    logic          pready;
    logic          pslverr;

    logic          fifo_rinc, pwrite, psel, penable, busy, tout;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [7:0]    err_count;

    logic          fifo_rinc2, pwrite2, psel2, penable2, busy2, tout2;
    logic [AW-1:0] paddr2;
    logic [DW-1:0] pwdata2;
    logic [1:0]    err_count2;

    apb_master_ctrl #(.DSIZE(DW), .AWIDTH(AW), .ECNT_W(8), .TIMEOUT_CYC(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
        .fifo_addr(fifo_addr), .fifo_rinc(fifo_rinc), .paddr(paddr), .pwdata(pwdata),
        .pwrite(pwrite), .psel(psel), .penable(penable), .pready(pready), .pslverr(pslverr),
        .busy(busy), .err_count(err_count), .tout(tout)
    );

    apb_master_ctrl #(.DSIZE(DW), .AWIDTH(AW), .ECNT_W(2), .TIMEOUT_CYC(16)) dut_sat (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
        .fifo_addr(fifo_addr), .fifo_rinc(fifo_rinc2), .paddr(paddr2), .pwdata(pwdata2),
        .pwrite(pwrite2), .psel(psel2), .penable(penable2), .pready(pready), .pslverr(pslverr),
        .busy(busy2), .err_count(err_count2), .tout(tout2)
    );

    always #5 rclk = ~rclk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic e; logic w; } xfer_t;

    ent_t  fifo_q[$];
    ent_t  exp_q[$];
    xfer_t obs_q[$];

    int n_tests, n_fail;
    int pops, viol, m_err;
    logic prev_setup;
    logic [AW-1:0] prev_addr;
    bit rand_rdy, rand_err;
    int rdy_pct;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive_fifo();
        fifo_rempty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            fifo_rdata = fifo_q[0].d;
            fifo_addr  = fifo_q[0].a;
        end else begin
            fifo_rdata = '0;
            fifo_addr  = '0;
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ent_t e;
        e.a = a;
        e.d = d;
        fifo_q.push_back(e);
        drive_fifo();
    endtask

    // one clock: observe pre-edge values at the falling edge, update the FIFO model after the rising edge
    task automatic cycle();
        @(negedge rclk);
        if (rrst_n) begin
            if (fifo_rinc && fifo_rempty) viol++;
            if (penable && !psel) viol++;
            if (prev_setup && !(psel && penable && paddr == prev_addr)) viol++;
            if ({fifo_rinc2, psel2, penable2, pwrite2, busy2, tout2} !== {fifo_rinc, psel, penable, pwrite, busy, tout}
                || paddr2 !== paddr || pwdata2 !== pwdata) viol++;
            prev_setup = psel && !penable;
            prev_addr  = paddr;
            if (fifo_rinc && fifo_q.size() != 0) begin
                exp_q.push_back(fifo_q[0]);
                void'(fifo_q.pop_front());
                pops++;
            end
            if (psel && penable && pready) begin
                obs_q.push_back('{paddr, pwdata, pslverr, pwrite});
                if (pslverr) m_err++;
            end
        end
        @(posedge rclk);
        #1;
        drive_fifo();
        if (rand_rdy) pready = ($urandom_range(99) < rdy_pct);
        if (rand_err) pslverr = $urandom_range(1) == 1;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        cycle();
        while ((fifo_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            cycle();
            n++;
        end
        n_tests++;
        if (busy !== 1'b0 || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b entries_left=%0d, required idle within %0d cycles", tag, busy, fifo_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        rrst_n   = 1'b0;
        rand_rdy = 0;
        rand_err = 0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        obs_q.delete();
        pops = 0; viol = 0; m_err = 0;
        prev_setup = 1'b0;
        drive_fifo();
        repeat (2) @(posedge rclk);
        #2;
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        fifo_q.delete();
        push(32'h0000_ABC0, 32'h1234_5678);
        #3;
        n_tests++;
        if (fifo_rinc !== 1'b0) begin
            n_fail++; $display("FAIL reset_rinc: got %b required 0", fifo_rinc);
        end
        n_tests++;
        if ({psel, penable, pwrite, busy, tout} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: psel/penable/pwrite/busy/tout=%b required 00000", {psel, penable, pwrite, busy, tout});
        end
        n_tests++;
        if (paddr !== '0 || pwdata !== '0 || err_count !== '0) begin
            n_fail++; $display("FAIL reset_regs: paddr=%h pwdata=%h err=%0d required 0", paddr, pwdata, err_count);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        pready = 1'b1;
        push(32'h0000_0010, 32'hDEAD_BEEF);
        #1;
        n_tests++;
        if (fifo_rinc !== 1'b1) begin
            n_fail++; $display("FAIL t1_pop: rinc=%b required 1", fifo_rinc);
        end
        cycle();
        n_tests++;
        if ({psel, penable, pwrite, busy} !== 4'b1011 || paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL t1_setup: sel/en/wr/busy=%b addr=%h data=%h required 1011 10 deadbeef",
                               {psel, penable, pwrite, busy}, paddr, pwdata);
        end
        cycle();
        n_tests++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++; $display("FAIL t1_access: sel/en=%b required 11", {psel, penable});
        end
        cycle();
        n_tests++;
        if ({psel, penable, pwrite, busy} !== 4'b0 || paddr !== 32'h10 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL t1_done: sel/en/wr/busy=%b addr=%h err=%0d required 0000 10 0",
                               {psel, penable, pwrite, busy}, paddr, err_count);
        end
        n_tests++;
        if (pops != 1 || obs_q.size() != 1 || viol != 0) begin
            n_fail++; $display("FAIL t1_count: pops=%0d xfers=%0d viol=%0d required 1 1 0", pops, obs_q.size(), viol);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ea [3] = '{32'h4, 32'h8, 32'hC};
        logic [DW-1:0] ed [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        pready = 1'b1;
        for (int k = 0; k < 3; k++) push(ea[k], ed[k]);
        for (int i = 0; i < 6; i++) begin
            logic exp_en;
            cycle();
            exp_en = (i % 2) == 1;
            n_tests++;
            if (psel !== 1'b1 || penable !== exp_en) begin
                n_fail++; $display("FAIL t2_phase%0d: sel=%b en=%b required 1 %b", i, psel, penable, exp_en);
            end
        end
        cycle();
        n_tests++;
        if (psel !== 1'b0 || busy !== 1'b0 || pops != 3 || viol != 0) begin
            n_fail++; $display("FAIL t2_end: sel=%b busy=%b pops=%0d viol=%0d required 0 0 3 0", psel, busy, pops, viol);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_q.size() <= k || obs_q[k].a !== ea[k] || obs_q[k].d !== ed[k]) begin
                n_fail++; $display("FAIL t2_order%0d: got %h/%h required %h/%h", k,
                                   (obs_q.size() > k) ? obs_q[k].a : 32'hx, (obs_q.size() > k) ? obs_q[k].d : 32'hx, ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        push(32'h100, 32'hA5A5_0001);
        cycle();
        cycle();
        for (int w = 0; w < 4; w++) begin
            if (w == 1) begin
                push(32'h200, 32'hA5A5_0002);
                #1;
            end
            n_tests++;
            if ({psel, penable} !== 2'b11 || paddr !== 32'h100 || pwdata !== 32'hA5A5_0001 || fifo_rinc !== 1'b0) begin
                n_fail++; $display("FAIL t3_wait%0d: sel/en=%b addr=%h data=%h rinc=%b required 11 100 a5a50001 0",
                                   w, {psel, penable}, paddr, pwdata, fifo_rinc);
            end
            cycle();
        end
        pready = 1'b1;
        #1;
        n_tests++;
        if (fifo_rinc !== 1'b1) begin
            n_fail++; $display("FAIL t3_complete_pop: rinc=%b required 1", fifo_rinc);
        end
        cycle();
        n_tests++;
        if ({psel, penable} !== 2'b10 || paddr !== 32'h200 || pwdata !== 32'hA5A5_0002) begin
            n_fail++; $display("FAIL t3_next: sel/en=%b addr=%h data=%h required 10 200 a5a50002", {psel, penable}, paddr, pwdata);
        end
        run_until_idle(10, "t3");
        n_tests++;
        if (pops != 2 || obs_q.size() != 2 || viol != 0) begin
            n_fail++; $display("FAIL t3_count: pops=%0d xfers=%0d viol=%0d required 2 2 0", pops, obs_q.size(), viol);
        end
    endtask

    task automatic test_slave_error();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push(32'h300 + 32'(4 * k), 32'hE000_0000 + 32'(k));
            pready = 1'b0; pslverr = 1'b1;
            cycle();
            pready = 1'b1; pslverr = 1'b1;
            cycle();
            pready = 1'b0; pslverr = 1'b1;
            cycle();
            pready = 1'b1; pslverr = (k != 1);
            cycle();
            pready = 1'b0; pslverr = 1'b0;
            if (k == 2) begin
                n_tests++;
                if (err_count !== 8'd2 || err_count2 !== 2'd2) begin
                    n_fail++; $display("FAIL t4_count: err=%0d err_sat=%0d required 2 2", err_count, err_count2);
                end
            end
        end
        n_tests++;
        if (err_count !== 8'(sat(m_err, 255)) || err_count !== 8'd5) begin
            n_fail++; $display("FAIL t4_total: err=%0d required 5", err_count);
        end
        n_tests++;
        if (err_count2 !== 2'd3) begin
            n_fail++; $display("FAIL t4_saturate: err_sat=%0d required 3", err_count2);
        end
        n_tests++;
        if (obs_q.size() != 6 || viol != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t4_xfers: xfers=%0d viol=%0d busy=%b required 6 0 0", obs_q.size(), viol, busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        push(32'h400, 32'hAAAA_0000);
        cycle();
        cycle();
`ifdef APB_TIMEOUT_EN
        repeat (15) cycle();
        push(32'h404, 32'hBBBB_0000);
        #1;
        n_tests++;
        if ({psel, penable} !== 2'b11 || fifo_rinc !== 1'b0) begin
            n_fail++; $display("FAIL t5_limit_cycle: sel/en=%b rinc=%b required 11 0", {psel, penable}, fifo_rinc);
        end
        cycle();
        void'(exp_q.pop_front());
        m_err++;
        n_tests++;
        if ({psel, penable, busy} !== 3'b000 || tout !== 1'b1 || err_count !== 8'd1) begin
            n_fail++; $display("FAIL t5_abort: sel/en/busy=%b tout=%b err=%0d required 000 1 1", {psel, penable, busy}, tout, err_count);
        end
        pready = 1'b1;
        run_until_idle(10, "t5");
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0].a !== 32'h404 || tout !== 1'b1) begin
            n_fail++; $display("FAIL t5_next: xfers=%0d tout=%b required 1 xfer to 404, tout 1", obs_q.size(), tout);
        end
        push(32'h408, 32'hCCCC_0000);
        pready = 1'b0;
        cycle();
        cycle();
        repeat (15) cycle();
        pready = 1'b1;
        cycle();
        n_tests++;
        if (err_count !== 8'd1 || obs_q.size() != 2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_ready_wins: err=%0d xfers=%0d busy=%b required 1 2 0", err_count, obs_q.size(), busy);
        end
`else
        push(32'h404, 32'hBBBB_0000);
        repeat (40) cycle();
        n_tests++;
        if ({psel, penable} !== 2'b11 || paddr !== 32'h400 || fifo_rinc !== 1'b0) begin
            n_fail++; $display("FAIL t5_hold: sel/en=%b addr=%h rinc=%b required 11 400 0", {psel, penable}, paddr, fifo_rinc);
        end
        n_tests++;
        if (tout !== 1'b0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL t5_no_tout: tout=%b err=%0d required 0 0", tout, err_count);
        end
        pready = 1'b1;
        run_until_idle(10, "t5");
        n_tests++;
        if (obs_q.size() != 2 || obs_q[0].a !== 32'h400 || obs_q[1].a !== 32'h404) begin
            n_fail++; $display("FAIL t5_release: xfers=%0d required 2 (400 then 404)", obs_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        push(32'h500, 32'h5000_0000);
        push(32'h504, 32'h5000_0001);
        push(32'h508, 32'h5000_0002);
        cycle();
        cycle();
        cycle();
        #1;
        rrst_n = 1'b0;
        #1;
        n_tests++;
        if ({psel, penable, busy, fifo_rinc} !== 4'b0000) begin
            n_fail++; $display("FAIL t6_async: sel/en/busy/rinc=%b required 0000", {psel, penable, busy, fifo_rinc});
        end
        exp_q.delete();
        m_err = 0;
        prev_setup = 1'b0;
        @(posedge rclk);
        #2;
        rrst_n = 1'b1;
        pready = 1'b1;
        run_until_idle(20, "t6");
        n_tests++;
        if (obs_q.size() != 2 || pops != 3 || viol != 0) begin
            n_fail++; $display("FAIL t6_count: xfers=%0d pops=%0d viol=%0d required 2 3 0", obs_q.size(), pops, viol);
        end
        n_tests++;
        if (obs_q.size() < 2 || obs_q[0].a !== 32'h504 || obs_q[1].a !== 32'h508 || obs_q[1].d !== 32'h5000_0002) begin
            n_fail++; $display("FAIL t6_order: first=%h second=%h required 504 508",
                               (obs_q.size() > 0) ? obs_q[0].a : 32'hx, (obs_q.size() > 1) ? obs_q[1].a : 32'hx);
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int n = 0;
        int bad = 0;
        do_reset();
        rand_rdy = 1;
        rand_err = 1;
        rdy_pct  = 70;
        while ((pushed < 40 || fifo_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
            if (pushed < 40 && $urandom_range(2) == 0) begin
                push($urandom() & 32'hFFFF_FFFC, $urandom());
                pushed++;
            end
            cycle();
            n++;
        end
        n_tests++;
        if (n >= 3000) begin
            n_fail++; $display("FAIL rnd_drain: busy=%b left=%0d pushed=%0d, required idle within 3000 cycles", busy, fifo_q.size(), pushed);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            if (obs_q[k].a !== exp_q[k].a || obs_q[k].d !== exp_q[k].d || obs_q[k].w !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0 || obs_q.size() != 40 || exp_q.size() != 40) begin
            n_fail++; $display("FAIL rnd_xfers: bad=%0d xfers=%0d pops=%0d required 0 40 40", bad, obs_q.size(), exp_q.size());
        end
        n_tests++;
        if (err_count !== 8'(sat(m_err, 255)) || err_count2 !== 2'(sat(m_err, 3))) begin
            n_fail++; $display("FAIL rnd_err: err=%0d err_sat=%0d required %0d %0d", err_count, err_count2, sat(m_err, 255), sat(m_err, 3));
        end
        n_tests++;
        if (viol != 0 || pops != 40) begin
            n_fail++; $display("FAIL rnd_protocol: viol=%0d pops=%0d required 0 40", viol, pops);
        end
        rand_rdy = 0;
        rand_err = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        pops = 0; viol = 0; m_err = 0;
        rand_rdy = 0; rand_err = 0; rdy_pct = 100;
        prev_setup = 1'b0; prev_addr = '0;
        pready = 1'b0; pslverr = 1'b0;
        drive_fifo();
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_states();
        test_slave_error();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
